// File: rtl/lotr_pkg.sv
// Shared defaults and the raw input bundle type for the board I/O conditioner.
package lotr_pkg;

  localparam int unsigned LOTR_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned LOTR_SYNC_STAGES     = 2;

  localparam int unsigned SW_W  = 10;
  localparam int unsigned ARD_W = 16;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic             button_0;
    logic             button_1;
    logic [SW_W-1:0]  sw;
    logic [ARD_W-1:0] arduino;
  } t_io_cond_in;

endpackage

// File: rtl/lotr_debounce_bit.sv
// One debounced input bit: synchronizer chain, stability counter and debounced flop.
module lotr_debounce_bit
  import lotr_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'(LOTR_DEBOUNCE_CYCLES),
  parameter int unsigned SYNC_STAGES     = LOTR_SYNC_STAGES,
  parameter logic        IDLE            = 1'b0,
  parameter logic        INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync;
  logic [15:0]            cnt;
  logic                   level;
  logic                   hit;

  // Synchronizer parks at the idle raw level while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {SYNC_STAGES{IDLE}};
    else        sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  assign level  = sync[SYNC_STAGES-1] ^ INVERT;
  assign hit    = (cnt == DEBOUNCE_CYCLES - 16'd1);
  assign rise_c = hit && level && !deb;

  // Counter runs only while the synchronized level disagrees with the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (level == deb) begin
      cnt <= '0;
    end else if (hit) begin
      deb <= level;
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/lotr_io_cond.sv
// Board I/O conditioner: debounced buttons/switches, synchronized Arduino pins.
// Define LOTR_IO_PRESS_CNT_EN to build the saturating Button_1 press counter.
module lotr_io_cond
  import lotr_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'(LOTR_DEBOUNCE_CYCLES),
  parameter int unsigned SYNC_STAGES     = LOTR_SYNC_STAGES
) (
  input  logic              QClk,
  input  logic              RstQnnnL,
  input  logic              Button_0_raw,
  input  logic              Button_1_raw,
  input  logic [SW_W-1:0]   Switch_raw,
  input  logic [ARD_W-1:0]  Arduino_raw,
  output logic              Button_0,
  output logic              Button_1,
  output logic              Button_1_Press,
  output logic [SW_W-1:0]   Switch,
  output logic [ARD_W-1:0]  Arduino_dg_io,
  output logic [CNT_W-1:0]  PressCount
);

  t_io_cond_in raw_in;
  logic                          rise_b0;
  logic                          rise_b1;
  logic [SW_W-1:0]               rise_sw;
  logic                          unused_rise;
  logic [SYNC_STAGES-1:0][ARD_W-1:0] ard_sync;

  assign raw_in.button_0 = Button_0_raw;
  assign raw_in.button_1 = Button_1_raw;
  assign raw_in.sw       = Switch_raw;
  assign raw_in.arduino  = Arduino_raw;

  // Buttons are active-low on the board; outputs are active-high
  lotr_debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES),
    .IDLE(1'b1), .INVERT(1'b1)
  ) u_btn0 (
    .clk(QClk), .rst_n(RstQnnnL), .raw(raw_in.button_0),
    .deb(Button_0), .rise_c(rise_b0)
  );

  lotr_debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES),
    .IDLE(1'b1), .INVERT(1'b1)
  ) u_btn1 (
    .clk(QClk), .rst_n(RstQnnnL), .raw(raw_in.button_1),
    .deb(Button_1), .rise_c(rise_b1)
  );

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    lotr_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES),
      .IDLE(1'b0), .INVERT(1'b0)
    ) u_deb (
      .clk(QClk), .rst_n(RstQnnnL), .raw(raw_in.sw[i]),
      .deb(Switch[i]), .rise_c(rise_sw[i])
    );
  end

  assign unused_rise = ^{rise_b0, rise_sw};

  // Press pulse lands on the same edge Button_1 goes high
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) Button_1_Press <= 1'b0;
    else           Button_1_Press <= rise_b1;
  end

  // Arduino pins: synchronized only, idle-high pins read back as 0
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) ard_sync <= '1;
    else           ard_sync <= {ard_sync[SYNC_STAGES-2:0], raw_in.arduino};
  end

  assign Arduino_dg_io = ~ard_sync[SYNC_STAGES-1];

`ifdef LOTR_IO_PRESS_CNT_EN
  logic [CNT_W-1:0] press_count;

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL)
      press_count <= '0;
    else if (Button_1_Press && (press_count != 16'hFFFF))
      press_count <= press_count + 16'd1;
  end

  assign PressCount = press_count;
`else
  assign PressCount = '0;
`endif

endmodule

// File: doc/lotr_io_cond.md
LOTR_IO_COND -- requirements
Module: lotr_io_cond

Interface
- REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000: consecutive stable cycles needed before a debounced output changes; legal range 1..65535.
- REQ-002 Parameter SYNC_STAGES, default 2: flop depth of every input synchronizer; legal range 2..4.
- REQ-003 QClk  input  1: the only clock; all flops on its rising edge.
- REQ-004 RstQnnnL  input  1: asynchronous reset, active-low; assertion is asynchronous, deassertion is on a QClk edge.
- REQ-005 Button_0_raw  input  1: board push-button, active-low, asynchronous.
- REQ-006 Button_1_raw  input  1: board push-button, active-low, asynchronous.
- REQ-007 Switch_raw  input  10: board slide switches, active-high, asynchronous.
- REQ-008 Arduino_raw  input  16: Arduino header pins, active-low, asynchronous.
- REQ-009 Button_0  output  1: debounced Button_0, active-high (1 = pressed).
- REQ-010 Button_1  output  1: debounced Button_1, active-high.
- REQ-011 Button_1_Press  output  1: one-cycle pulse on each debounced 0->1 transition of Button_1.
- REQ-012 Switch  output  10: debounced switches, one debouncer per bit.
- REQ-013 Arduino_dg_io  output  16: synchronized and inverted Arduino_raw, active-high, not debounced.
- REQ-014 PressCount  output  16: number of Button_1 presses, saturating.

Function
- REQ-015 Every raw input bit shall pass through a SYNC_STAGES-deep flop chain before any other logic.
- REQ-016 Each debounced bit shall have its own 16-bit stability counter.
- REQ-017 Counter update rule: cleared on every cycle the synchronized value (normalized to active-high) equals the debounced output; otherwise incremented.
- REQ-018 The debounced output shall take the synchronized value, and the counter shall clear, on the edge where the counter equals DEBOUNCE_CYCLES-1.
- REQ-019 Latency: a raw change held stable changes the debounced output exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
- REQ-020 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall leave the debounced output unchanged and clear the counter.
- REQ-021 With DEBOUNCE_CYCLES=1, the debounced output shall follow the synchronized value with one cycle of delay.
- REQ-022 Button_1_Press shall be high for exactly the one cycle after Button_1 rises, and never on a falling edge.
- REQ-023 PressCount shall increment by 1 on each Button_1_Press cycle and hold at 16'hFFFF (no wrap).
- REQ-024 Arduino_dg_io shall equal ~Arduino_raw delayed by SYNC_STAGES cycles.
- REQ-025 All outputs shall be registered; no combinational path from any raw input to any output.

Reset
- REQ-026 While RstQnnnL=0: Button_0=0, Button_1=0, Button_1_Press=0, Switch=0, Arduino_dg_io=0, PressCount=0, all counters=0.
- REQ-027 While RstQnnnL=0, synchronizer flops shall hold the idle raw level: 1 for buttons and Arduino, 0 for switches.
- REQ-028 A reset asserted mid-debounce shall discard the partial count; no pulse or count shall be produced on reset release.

Configuration
- REQ-029 Macro LOTR_IO_PRESS_CNT_EN shall control the press counter.
- REQ-030 When LOTR_IO_PRESS_CNT_EN is defined, the PressCount counter shall be compiled in and behave as in REQ-023.
- REQ-031 When LOTR_IO_PRESS_CNT_EN is not defined, the counter flops shall be absent, PressCount shall be tied to 16'h0000, and all other behaviour shall be unchanged.

Structure
- REQ-032 lotr_pkg shall hold the default constants LOTR_DEBOUNCE_CYCLES and LOTR_SYNC_STAGES.
- REQ-033 lotr_pkg shall hold a typedef t_io_cond_in bundling the raw input widths.
- REQ-034 One sub-module, lotr_debounce_bit (synchronizer + counter + debounced flop), shall be instantiated once per debounced bit, 12 instances in total.

Verification (bench: DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
- REQ-035 Case 1: Button_1_raw 1->0, held 10 cycles -> Button_1=1 exactly 6 cycles after the change; Button_1_Press high for 1 cycle; PressCount=1.
- REQ-036 Case 2: Switch_raw[3] pulsed high for 3 cycles -> Switch[3] stays 0, counter returns to 0.
- REQ-037 Case 3: Arduino_raw=16'h00FF -> Arduino_dg_io=16'hFF00 after 2 cycles.
- REQ-038 Case 4: PressCount preloaded to 16'hFFFE (force), then 3 presses -> PressCount=16'hFFFF and held.
- REQ-039 Case 5: RstQnnnL pulled low 2 cycles into a Button_0 debounce, released with the raw level still low -> all outputs 0 during reset; Button_0=1 only 6 cycles after release; no Press pulse during reset.
- REQ-040 Case 6: build without LOTR_IO_PRESS_CNT_EN -> PressCount=0 after 5 presses; Button_1_Press pulses unchanged.
